// File: rtl/obstacle_spawner_if.sv
// Bundle of the spawner's control inputs (tick/start/collision/random) and its
// registered playfield outputs; the game FSM drives it as master, the spawner is the slave.
interface obstacle_spawner_if #(
    parameter int NUM_OBS = 3,
    parameter int X_W     = 10
);
    logic                     tick;
    logic                     start;
    logic                     collision;
    logic [4:0]               random1;
    logic [NUM_OBS-1:0]       obs_valid;
    logic [NUM_OBS*X_W-1:0]   obs_x;
    logic [NUM_OBS*2-1:0]     obs_type;
    logic                     spawn;
    logic                     running;
    logic [7:0]               passed_count;

    modport master (
        output tick, start, collision, random1,
        input  obs_valid, obs_x, obs_type, spawn, running, passed_count
    );

    modport slave (
        input  tick, start, collision, random1,
        output obs_valid, obs_x, obs_type, spawn, running, passed_count
    );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle scheduler for the dino game: a random gap timer fills a small slot table at the
// right screen edge, slots scroll left on each frame tick and expired ones are counted.
module obstacle_spawner #(
    parameter int NUM_OBS = 3,
    parameter int X_W     = 10,
    parameter int SPAWN_X = 640,
    parameter int SPEED   = 4,
    parameter int MIN_GAP = 24,
    parameter int GAP_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    obstacle_spawner_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_OBS-1:0]              valid_q, valid_d;
    logic [NUM_OBS-1:0][X_W-1:0]     x_q, x_d;
    logic [NUM_OBS-1:0][1:0]         type_q, type_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [7:0]                      passed_q, passed_d;
    logic                            spawn_q, spawn_d;
    logic                            running_q, running_d;

    logic [8:0]                      expire_cnt;
    logic [8:0]                      passed_sum;

    logic [NUM_OBS*X_W-1:0]          obs_x_flat;
    logic [NUM_OBS*2-1:0]            obs_type_flat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            valid_q   <= '0;
            x_q       <= '0;
            type_q    <= '0;
            gap_q     <= '0;
            passed_q  <= '0;
            spawn_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            type_q    <= type_d;
            gap_q     <= gap_d;
            passed_q  <= passed_d;
            spawn_q   <= spawn_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        x_d        = x_q;
        type_d     = type_q;
        gap_d      = gap_q;
        passed_d   = passed_q;
        spawn_d    = 1'b0;
        expire_cnt = '0;
        passed_sum = '0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    valid_d  = '0;
                    x_d      = '0;
                    type_d   = '0;
                    passed_d = '0;
                    gap_d    = GAP_W'(MIN_GAP);
                end
            end
            ST_RUN: begin
                // A collision freezes the scene even when a tick arrives in the same cycle.
                if (bus.collision) begin
                    state_d = ST_HALT;
                end else if (bus.tick) begin
                    for (int i = 0; i < NUM_OBS; i++) begin
                        if (valid_q[i]) begin
                            if (x_q[i] < X_W'(SPEED)) begin
                                valid_d[i] = 1'b0;
                                expire_cnt = expire_cnt + 9'd1;
                            end else begin
                                x_d[i] = x_q[i] - X_W'(SPEED);
                            end
                        end
                    end

                    passed_sum = {1'b0, passed_q} + expire_cnt;
                    passed_d   = (passed_sum > 9'd255) ? 8'd255 : passed_sum[7:0];

                    // Free slots are judged after this tick's expiries; a full table keeps
                    // the timer at zero so the spawn is retried on the next tick.
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end else begin
                        for (int i = 0; i < NUM_OBS; i++) begin
                            if (!spawn_d && !valid_d[i]) begin
                                valid_d[i] = 1'b1;
                                x_d[i]     = X_W'(SPAWN_X);
                                type_d[i]  = bus.random1[1:0];
                                spawn_d    = 1'b1;
                                gap_d      = GAP_W'(MIN_GAP) + GAP_W'(bus.random1);
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_flat
        assign obs_x_flat[gi*X_W +: X_W] = x_q[gi];
        assign obs_type_flat[gi*2 +: 2]  = type_q[gi];
    end

    assign bus.obs_valid    = valid_q;
    assign bus.obs_x        = obs_x_flat;
    assign bus.obs_type     = obs_type_flat;
    assign bus.spawn        = spawn_q;
    assign bus.running      = running_q;
    assign bus.passed_count = passed_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomized scoreboard bench for obstacle_spawner: a behavioural playfield model predicts
// the outputs after every cycle and a separate monitor compares them against the DUT.
module tb_obstacle_spawner;

    localparam int NUM_OBS = 3;
    localparam int X_W     = 10;
    localparam int SPAWN_X = 640;
    localparam int SPEED   = 4;
    localparam int MIN_GAP = 24;
    localparam int GAP_W   = 7;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        int                       cyc;
        logic [NUM_OBS-1:0]       v;
        logic [NUM_OBS*X_W-1:0]   x;
        logic [NUM_OBS*2-1:0]     t;
        logic                     sp;
        logic                     run;
        logic [7:0]               pc;
    } snap_t;

    logic clk;
    logic rst_n;
    int   cyc_cnt;
    int   n_checks;
    int   n_pass;
    snap_t exp_q[$];

    // Behavioural model state
    int m_mode;
    bit m_v[NUM_OBS];
    int m_x[NUM_OBS];
    int m_t[NUM_OBS];
    int m_gap;
    int m_passed;
    bit m_spawn;
    int m_total_exp;

    obstacle_spawner_if #(.NUM_OBS(NUM_OBS), .X_W(X_W)) bus ();

    obstacle_spawner #(
        .NUM_OBS(NUM_OBS), .X_W(X_W), .SPAWN_X(SPAWN_X),
        .SPEED(SPEED), .MIN_GAP(MIN_GAP), .GAP_W(GAP_W)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_gap    = 0;
        m_passed = 0;
        m_spawn  = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            m_v[i] = 1'b0;
            m_x[i] = 0;
            m_t[i] = 0;
        end
    endtask

    task automatic model_eval(input bit tk, input bit st, input bit co, input int r);
        int n;
        int idx;
        m_spawn = 1'b0;
        if (m_mode != M_RUN && st) begin
            m_mode   = M_RUN;
            m_passed = 0;
            m_gap    = MIN_GAP;
            for (int i = 0; i < NUM_OBS; i++) begin
                m_v[i] = 1'b0;
                m_x[i] = 0;
                m_t[i] = 0;
            end
        end else if (m_mode == M_RUN && co) begin
            m_mode = M_HALT;
        end else if (m_mode == M_RUN && tk) begin
            n = 0;
            for (int i = 0; i < NUM_OBS; i++) begin
                if (m_v[i]) begin
                    if (m_x[i] < SPEED) begin
                        m_v[i] = 1'b0;
                        n++;
                    end else begin
                        m_x[i] = m_x[i] - SPEED;
                    end
                end
            end
            m_total_exp += n;
            m_passed = (m_passed + n > 255) ? 255 : m_passed + n;
            if (m_gap > 0) begin
                m_gap--;
            end else begin
                idx = -1;
                for (int i = 0; i < NUM_OBS; i++)
                    if (idx < 0 && !m_v[i]) idx = i;
                if (idx >= 0) begin
                    m_v[idx] = 1'b1;
                    m_x[idx] = SPAWN_X;
                    m_t[idx] = r % 4;
                    m_spawn  = 1'b1;
                    m_gap    = MIN_GAP + r;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, predict the registered outputs, and advance the clock.
    task automatic step(input bit tk, input bit st, input bit co, input int r);
        snap_t s;
        bus.tick      = tk;
        bus.start     = st;
        bus.collision = co;
        bus.random1   = 5'(r);
        model_eval(tk, st, co, r);
        s.cyc = cyc_cnt + 1;
        for (int i = 0; i < NUM_OBS; i++) begin
            s.v[i]              = m_v[i];
            s.x[i*X_W +: X_W]   = X_W'(m_x[i]);
            s.t[i*2 +: 2]       = 2'(m_t[i]);
        end
        s.sp  = m_spawn;
        s.run = (m_mode == M_RUN);
        s.pc  = 8'(m_passed);
        exp_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (bus.obs_valid === '0 && bus.obs_x === '0 && bus.obs_type === '0 &&
            bus.spawn === 1'b0 && bus.running === 1'b0 && bus.passed_count === 8'd0)
            n_pass++;
        else
            $display("FAIL %s: valid=%b x=%h type=%h spawn=%b running=%b passed=%0d, required all zero",
                     name, bus.obs_valid, bus.obs_x, bus.obs_type, bus.spawn, bus.running,
                     bus.passed_count);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // Monitor: pops the prediction due this cycle and compares the whole output set.
    always @(negedge clk) begin
        snap_t s;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
                s = exp_q.pop_front();
                n_checks++;
                $display("FAIL stale prediction for cyc=%0d seen at cyc=%0d", s.cyc, cyc_cnt);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
                s = exp_q.pop_front();
                n_checks++;
                if (bus.obs_valid === s.v && bus.obs_x === s.x && bus.obs_type === s.t &&
                    bus.spawn === s.sp && bus.running === s.run && bus.passed_count === s.pc)
                    n_pass++;
                else
                    $display("FAIL outputs cyc=%0d (actual/required): valid %b/%b x %h/%h type %h/%h spawn %b/%b running %b/%b passed %0d/%0d",
                             cyc_cnt, bus.obs_valid, s.v, bus.obs_x, s.x, bus.obs_type, s.t,
                             bus.spawn, s.sp, bus.running, s.run, bus.passed_count, s.pc);
            end
        end
    end

    initial begin
        int first_sp;
        int second_sp;
        int budget;
        n_checks = 0;
        n_pass   = 0;
        m_total_exp = 0;
        rst_n = 1'b0;
        bus.tick = 1'b0;
        bus.start = 1'b0;
        bus.collision = 1'b0;
        bus.random1 = 5'd0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;

        // No start: ticks must not spawn or run.
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 31));

        // Start with random1=0: spawns on the 25th and 50th tick.
        step(1'b0, 1'b1, 1'b0, 0);
        first_sp  = -1;
        second_sp = -1;
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            if (bus.spawn === 1'b1) begin
                if (first_sp < 0) first_sp = k;
                else if (second_sp < 0) second_sp = k;
            end
        end
        check_int("first_spawn_tick", first_sp, 25);
        check_int("second_spawn_tick", second_sp, 50);

        // Long gaps with random1=31 and a full table: blocked spawns retried each tick.
        for (int i = 0; i < 400; i++) step(1'b1, 1'b0, 1'b0, 31);

        // start in RUN is ignored; collision+tick freezes; ticks in HALT ignored; restart.
        step(1'b1, 1'b1, 1'b0, 5);
        step(1'b1, 1'b0, 1'b1, 7);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 31));
        step(1'b1, 1'b1, 1'b0, 3);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 31));

        // Random control traffic.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 299) == 0), $urandom_range(0, 31));

        // Saturation: restart and tick continuously until at least 300 expiries this run.
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        m_total_exp = 0;
        budget = 0;
        while (m_total_exp < 300 && budget < 40000) begin
            step(1'b1, 1'b0, 1'b0, $urandom_range(0, 31));
            budget++;
        end
        check_int("saturation_reached_in_budget", (budget < 40000) ? 1 : 0, 1);
        check_int("passed_count_saturated", int'(bus.passed_count), 255);

        // Asynchronous reset in the middle of the run.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_midrun");
        exp_q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 31));

        repeat (3) @(negedge clk);
        #1;
        check_int("predictions_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
